spectrum_frame_buffer: RTL

- Double-buffered bar-height store between the FFT magnitude stream and the VGA pixel generator; the pixel generator drives its 9-bit address and reads back 8-bit data.
- The writer fills the back bank from a valid/ready stream, scaling and saturating each magnitude to 8 bits.
- Banks swap only at the start of vertical sync, so a displayed frame never tears.
- frame_ready drives the VGA external-data-control input.

---
 rtl/spectrum_frame_buffer_if.sv | 31 +++
 rtl/spectrum_frame_buffer.sv | 108 ++++++++++
 2 files changed

// File: rtl/spectrum_frame_buffer_if.sv
// Stream-in and pixel-read bundle for the spectrum frame buffer.
// Master is the FFT/pixel side; slave is the buffer itself.
interface spectrum_frame_buffer_if #(
  parameter int MAG_W = 16,
  parameter int AW    = 9
);
  logic             s_valid;
  logic             s_ready;
  logic [MAG_W-1:0] s_mag;
  logic             s_last;
  logic [AW-1:0]    rd_addr;
  logic [7:0]       rd_data;

  modport master (
    output s_valid,
    output s_mag,
    output s_last,
    output rd_addr,
    input  s_ready,
    input  rd_data
  );

  modport slave (
    input  s_valid,
    input  s_mag,
    input  s_last,
    input  rd_addr,
    output s_ready,
    output rd_data
  );
endinterface

// File: rtl/spectrum_frame_buffer.sv
// Double-buffered bar-height store: FFT magnitudes fill the back bank,
// the VGA pixel generator reads the front bank, banks swap on VSync fall.
module spectrum_frame_buffer #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int MAG_W = 16,
  parameter int SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spectrum_frame_buffer_if.slave bus,
  input  logic                  vsync,
  output logic                  frame_ready,
  output logic [7:0]            drop_cnt
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [AW:0] wr_idx;
  logic        front_sel;
  logic        vsync_q;
  logic        vsync_fall;
  logic        wr_en;
  logic        drop_inc;
  logic        idx_clr;
  logic        swap;
  logic [7:0]  rd_data_p1;

  logic [7:0]  mem [0:2*DEPTH-1];

  function automatic logic [7:0] scale_sat(input logic [MAG_W-1:0] mag);
    logic [MAG_W-1:0] h;
    h = mag >> SHIFT;
    if (h > MAG_W'(255)) return 8'hFF;
    return h[7:0];
  endfunction

  assign vsync_fall  = vsync_q && !vsync;
  assign bus.s_ready = (state == FILL);
  assign bus.rd_data = rd_data_p1;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    drop_inc  = 1'b0;
    idx_clr   = 1'b0;
    swap      = 1'b0;
    case (state)
      FILL: begin
        // VSync edges are ignored here: no swap without a completed frame.
        if (bus.s_valid) begin
          if (wr_idx < DEPTH_L) wr_en    = 1'b1;
          else                  drop_inc = 1'b1;
          if (bus.s_last) begin
            idx_clr   = 1'b1;
            state_nxt = WAIT_SWAP;
          end
        end
      end
      WAIT_SWAP: begin
        if (vsync_fall) begin
          swap      = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      wr_idx      <= '0;
      front_sel   <= 1'b0;
      vsync_q     <= 1'b1;
      frame_ready <= 1'b0;
      drop_cnt    <= 8'd0;
    end else begin
      state   <= state_nxt;
      vsync_q <= vsync;
      if (idx_clr)    wr_idx <= '0;
      else if (wr_en) wr_idx <= wr_idx + 1'b1;
      if (swap) begin
        front_sel   <= ~front_sel;
        frame_ready <= 1'b1;
      end
      if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // p0 -> p1: write into the back bank, registered read from the front bank.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{~front_sel, wr_idx[AW-1:0]}] <= scale_sat(bus.s_mag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_p1 <= 8'd0;
    else        rd_data_p1 <= mem[{front_sel, bus.rd_addr}];
  end

endmodule
